// File: rtl/prio_stream_arb.sv
// rtl/prio_stream_arb.sv - registered fixed-priority / round-robin arbiter selecting the memory block feeding the merged stream
module prio_stream_arb #(
   parameter int NCH     = 12,
   parameter int SELW    = 4,
   parameter int RR_MODE = 0,
   parameter int CNTW    = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            first_dat,
   input  logic [NCH-1:0]  has_dat,
   input  logic            advance,
   output logic [NCH-1:0]  sel_oh,
   output logic [SELW-1:0] sel,
   output logic            grant_vld,
   output logic            none,
   output logic [CNTW-1:0] grant_cnt
);

   // Index width just wide enough to address has_dat.
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   // Pointer restarts at the last channel so channel 0 comes first in RR order.
   localparam logic [SELW-1:0] PTR_INIT = SELW'(NCH - 1);
   localparam logic [NCH-1:0]  ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

   logic [SELW-1:0] ptr;
   logic            win_found;
   logic [SELW-1:0] win_idx;
   logic            granted_live;
   logic            arb;
   int              cand;
   logic [IDXW-1:0] cidx;

   // Decide whether this cycle re-arbitrates: no grant, consumer moved on, or granted block ran dry.
   always_comb begin
      granted_live = |(has_dat & sel_oh);
      arb          = !grant_vld || advance || !granted_live;
   end

   // Winner search; loops run from lowest to highest priority so the last hit is the winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cidx      = '0;
      if (RR_MODE == 0) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            cidx = IDXW'(i);
            if (has_dat[cidx]) begin
               win_found = 1'b1;
               win_idx   = SELW'(i);
            end
         end
      end else begin
         // k = NCH is the pointer itself: the current holder is only eligible after everyone else.
         for (int k = NCH; k >= 1; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NCH) begin
               cand = cand - NCH;
            end
            cidx = IDXW'(cand);
            if (has_dat[cidx]) begin
               win_found = 1'b1;
               win_idx   = SELW'(cand);
            end
         end
      end
   end

   // Grant register: reset, then event restart, then arbitration; otherwise everything holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_oh    <= '0;
         sel       <= '0;
         grant_vld <= 1'b0;
         none      <= 1'b1;
         grant_cnt <= '0;
         ptr       <= PTR_INIT;
      end else if (first_dat) begin
         sel_oh    <= '0;
         sel       <= '1;
         grant_vld <= 1'b0;
         none      <= 1'b1;
         grant_cnt <= '0;
         ptr       <= PTR_INIT;
      end else if (arb) begin
         if (win_found) begin
            sel_oh    <= ONE_HOT0 << win_idx;
            sel       <= win_idx + SELW'(1);
            grant_vld <= 1'b1;
            none      <= 1'b0;
            ptr       <= win_idx;
            if (grant_cnt != {CNTW{1'b1}}) begin
               grant_cnt <= grant_cnt + CNTW'(1);
            end
         end else begin
            sel_oh    <= '0;
            sel       <= '0;
            grant_vld <= 1'b0;
            none      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prio_stream_arb.sv
// tb/tb_prio_stream_arb.sv - randomized and directed bench for prio_stream_arb against a behavioural model
module tb_prio_stream_arb;

   localparam int NCH = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset = 1'b1;
   logic           first_dat = 1'b0;
   logic           advance = 1'b0;
   logic [NCH-1:0] has_dat = '0;

   logic [NCH-1:0] so0, so1, so2;
   logic [3:0]     s0, s1, s2;
   logic           v0, v1, v2;
   logic           n0, n1, n2;
   logic [7:0]     c0, c1;
   logic [1:0]     c2;

   prio_stream_arb #(.NCH(NCH), .SELW(4), .RR_MODE(0), .CNTW(8)) u_fix (
      .clk(clk), .reset(reset), .first_dat(first_dat), .has_dat(has_dat), .advance(advance),
      .sel_oh(so0), .sel(s0), .grant_vld(v0), .none(n0), .grant_cnt(c0));

   prio_stream_arb #(.NCH(NCH), .SELW(4), .RR_MODE(1), .CNTW(8)) u_rr (
      .clk(clk), .reset(reset), .first_dat(first_dat), .has_dat(has_dat), .advance(advance),
      .sel_oh(so1), .sel(s1), .grant_vld(v1), .none(n1), .grant_cnt(c1));

   prio_stream_arb #(.NCH(NCH), .SELW(4), .RR_MODE(1), .CNTW(2)) u_rr2 (
      .clk(clk), .reset(reset), .first_dat(first_dat), .has_dat(has_dat), .advance(advance),
      .sel_oh(so2), .sel(s2), .grant_vld(v2), .none(n2), .grant_cnt(c2));

   int n_vec = 0;
   int n_err = 0;

   // Reference state per instance: granted channel (-1 = none), reported sel code, none flag, count, RR pointer.
   int m_g[3];
   int m_sel[3];
   int m_none[3];
   int m_cnt[3];
   int m_ptr[3];
   int m_rr[3]  = '{0, 1, 1};
   int m_max[3] = '{255, 255, 3};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input int rr, input int ptr, input logic [NCH-1:0] hd);
      if (rr == 0) begin
         for (int i = 0; i < NCH; i++) if (hd[i]) return i;
      end else begin
         for (int k = 1; k <= NCH; k++) if (hd[(ptr + k) % NCH]) return (ptr + k) % NCH;
      end
      return -1;
   endfunction

   task automatic model_step(input logic rst, input logic fd, input logic [NCH-1:0] hd, input logic adv);
      for (int n = 0; n < 3; n++) begin
         if (rst || fd) begin
            m_g[n] = -1; m_sel[n] = rst ? 0 : 15; m_none[n] = 1; m_cnt[n] = 0; m_ptr[n] = NCH - 1;
         end else if (m_g[n] < 0 || adv || !hd[m_g[n]]) begin
            int w;
            w = pick(m_rr[n], m_ptr[n], hd);
            m_g[n] = w;
            if (w >= 0) begin
               m_sel[n] = w + 1; m_none[n] = 0; m_ptr[n] = w;
               if (m_cnt[n] < m_max[n]) m_cnt[n]++;
            end else begin
               m_sel[n] = 0; m_none[n] = 1;
            end
         end
      end
   endtask

   task automatic check_inst(input int n, input logic [NCH-1:0] so, input logic [3:0] s,
                             input logic v, input logic nn, input logic [7:0] c);
      logic [NCH-1:0] e_oh;
      e_oh = (m_g[n] >= 0) ? (NCH'(1) << m_g[n]) : '0;
      check($sformatf("d%0d sel_oh", n), 32'(so), 32'(e_oh));
      check($sformatf("d%0d sel", n), 32'(s), 32'(m_sel[n]));
      check($sformatf("d%0d grant_vld", n), 32'(v), (m_g[n] >= 0) ? 32'd1 : 32'd0);
      check($sformatf("d%0d none", n), 32'(nn), 32'(m_none[n]));
      check($sformatf("d%0d grant_cnt", n), 32'(c), 32'(m_cnt[n]));
   endtask

   // Drive one cycle of inputs, advance the model, then compare all instances after the edge.
   task automatic step(input logic rst, input logic fd, input logic [NCH-1:0] hd, input logic adv);
      reset = rst; first_dat = fd; has_dat = hd; advance = adv;
      model_step(rst, fd, hd, adv);
      @(negedge clk);
      check_inst(0, so0, s0, v0, n0, c0);
      check_inst(1, so1, s1, v1, n1, c1);
      check_inst(2, so2, s2, v2, n2, {6'd0, c2});
   endtask

   initial begin
      logic [NCH-1:0] hd;
      // Reset state
      step(1, 0, '0, 0);
      check("rst sel", 32'(s0), 32'd0);
      check("rst none", 32'(n1), 32'd1);
      check("rst cnt", 32'(c1), 32'd0);

      // Fixed priority picks lowest set bit, then holds without advance
      step(0, 0, 12'h00C, 0);
      check("t1 sel_oh", 32'(so0), 32'h004);
      check("t1 sel", 32'(s0), 32'd3);
      check("t1 cnt", 32'(c0), 32'd1);
      step(0, 0, 12'h00D, 0);
      check("t1 hold sel", 32'(s0), 32'd3);

      // Round robin walks all channels; 2-bit counter saturates
      step(1, 0, '0, 0);
      for (int k = 0; k < 14; k++) begin
         step(0, 0, 12'hFFF, 1);
         check("t2 rr sel", 32'(s1), 32'((k % 12) + 1));
         check("t2 rr cnt", 32'(c1), 32'(k + 1));
         check("t5 sat cnt", 32'(c2), (k < 3) ? 32'(k + 1) : 32'd3);
      end
      step(1, 0, '0, 0);
      step(0, 0, 12'hFFF, 1);
      step(0, 0, 12'h801, 1);
      check("t2 wrap sel12", 32'(s1), 32'd12);
      step(0, 0, 12'h801, 1);
      check("t2 wrap sel1", 32'(s1), 32'd1);

      // Granted block empties without advance
      step(1, 0, '0, 0);
      step(0, 0, 12'h020, 0);
      check("t3 fix sel6", 32'(s0), 32'd6);
      check("t3 rr sel6", 32'(s1), 32'd6);
      step(0, 0, 12'h081, 0);
      check("t3 fix sel1", 32'(s0), 32'd1);
      check("t3 rr sel8", 32'(s1), 32'd8);
      step(0, 0, 12'h000, 0);
      check("t3 empty sel", 32'(s0), 32'd0);
      check("t3 empty vld", 32'(v1), 32'd0);
      check("t3 empty none", 32'(n0), 32'd1);

      // first_dat restart, and reset dominating first_dat
      step(0, 0, 12'h020, 0);
      step(0, 1, 12'h020, 0);
      check("t4 fd sel", 32'(s0), 32'hF);
      check("t4 fd sel_oh", 32'(so0), 32'd0);
      check("t4 fd cnt", 32'(c0), 32'd0);
      step(0, 0, 12'h020, 0);
      check("t4 regrant", 32'(s0), 32'd6);
      step(1, 1, 12'h020, 0);
      check("t4 rst+fd sel", 32'(s0), 32'd0);

      // Reset in the middle of a grant, RR restarts at channel 0
      step(0, 0, 12'h020, 0);
      step(1, 0, 12'h020, 0);
      check("t6 rst vld", 32'(v1), 32'd0);
      step(0, 0, 12'hFFF, 0);
      check("t6 rr restart", 32'(s1), 32'd1);

      // Random traffic against the model
      hd = 12'(($urandom));
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            hd = 12'($urandom);
            if ($urandom_range(0, 1) == 0) hd = hd & 12'($urandom) & 12'($urandom);
         end
         step(($urandom_range(0, 210) == 0), ($urandom_range(0, 96) == 0), hd,
              ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
